// File: rtl/twos_to_signmag_serial.sv
// rtl/twos_to_signmag_serial.sv - bit-serial two's-complement to sign-magnitude decoder
// LSB-first: copy bits up to and including the first 1, then invert the rest when negative.
module twos_to_signmag_serial #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sign,
    output logic [W-1:0] out_mag,
    output logic         busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_sr;
    logic [W-1:0]    r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_neg;
    logic            r_seen_one;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_out_sign;
    logic [W-1:0]    r_out_mag;
    logic            r_busy;

    logic            w_bit;
    logic            w_mag_bit;
    logic            w_any_one;
    logic            w_last;
    logic [W-1:0]    w_acc_next;

    assign w_bit      = r_sr[0];
    assign w_mag_bit  = r_neg ? (w_bit ^ r_seen_one) : w_bit;
    assign w_any_one  = r_seen_one | w_bit;
    assign w_last     = (r_cnt == LAST);
    assign w_acc_next = {w_mag_bit, r_acc[W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_seen_one  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_mag   <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sr       <= in_data;
                        r_neg      <= in_data[W-1];
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_seen_one <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr       <= {1'b0, r_sr[W-1:1]};
                    r_acc      <= w_acc_next;
                    r_seen_one <= w_any_one;
                    r_cnt      <= r_cnt + CW'(1);
                    if (w_last) begin
                        // A negative word always contains a 1, so negative zero cannot occur.
                        r_out_mag   <= w_acc_next;
                        r_out_sign  <= r_neg & w_any_one;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sign  = r_out_sign;
    assign out_mag   = r_out_mag;
    assign busy      = r_busy;
endmodule

// File: doc/twos_to_signmag_serial.md
Name: twos_to_signmag_serial

Overview:
- Bit-serial decoder that converts a two's-complement word into sign-magnitude form.
- It is the inverse of the complement-and-add path used by the 4-bit add/subtract unit. It takes that unit's 5-bit sign-extended sum/difference and recovers sign and magnitude for display or host readout.
- Uses one shift per bit, LSB first, with the copy-through-first-1-then-invert rule.
- Valid/ready handshakes on both sides.

Parameters:
- W, 5, word width of the two's-complement input and of the magnitude output.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  block can accept a word.
- in_data  input  W  two's-complement word; bit W-1 is the sign.
- out_valid  output  1  out_sign/out_mag hold a result.
- out_ready  input  1  downstream accepts the result.
- out_sign  output  1  1 = negative.
- out_mag  output  W  unsigned magnitude.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (async, any time, including mid-conversion): state=IDLE; in_ready=1, out_valid=0, out_sign=0, out_mag=0, busy=0; shift register, counter and seen_one flag cleared. Any partial conversion is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready at an edge: latch in_data into shift register sr, neg=in_data[W-1], cnt=0, seen_one=0, then go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1. Each edge processes bit b=sr[0].
  - Magnitude bit m = neg ? (b XOR seen_one) : b.
  - m shifts into the MSB of accumulator acc (acc shifts right); sr shifts right; seen_one |= b; cnt++.
  - When cnt reaches W-1 at an edge (the W-th bit), go to DONE. On that same edge: out_mag=final acc, out_sign=neg AND (any input bit set), out_valid=1.
- DONE:
  - out_valid=1, in_ready=0.
  - Outputs are held stable until out_valid&&out_ready at an edge. Then out_valid=0 and the block returns to IDLE; in_ready=1 from the next cycle.
  - out_mag/out_sign keep their last values after handoff and are not cleared.
- Latency: result is visible exactly W cycles after the accepting edge (5 for default). Throughput is one word per W+2 cycles minimum with out_ready held high.
- Width rules:
  - Most negative input -2^(W-1) yields out_sign=1, out_mag=2^(W-1). This fits in W unsigned bits, so there is no overflow flag.
  - Zero yields out_sign=0, out_mag=0; negative zero is never produced.
- in_valid while not in IDLE is ignored; the word is not captured, and upstream must hold it.
- out_ready while out_valid=0 has no effect.
- in_data changing during SHIFT has no effect because the word was latched.

Test Plan:
- Reset, then present in_data=5'b01011 (+11) -> after 5 cycles out_valid=1, out_sign=0, out_mag=5'd11; busy high for exactly 5 cycles.
- in_data=5'b10101 (-11) -> out_sign=1, out_mag=5'd11. in_data=5'b11111 (-1) -> out_sign=1, out_mag=5'd1.
- in_data=5'b10000 (-16) -> out_sign=1, out_mag=5'b10000. in_data=5'b00000 -> out_sign=0, out_mag=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0. A second in_valid word is not taken until the cycle after out_ready=1 completes the handoff.
- Reset mid-operation: assert rst 2 cycles into SHIFT of 5'b10101 -> outputs immediately 0, in_ready=1. After release, a new word 5'b00111 converts cleanly to sign 0, mag 7.
- Back-to-back: feed all 32 values with out_ready=1 and compare each against a reference sign/|value| model -> zero mismatches; spacing is W+2 cycles per word.
